// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and its E-stage initiator.
// Op codes match the MD unit's own decoder; latency defaults describe the
// number of cycles the unit holds Busy after the Start edge.
package md_pkg;

    typedef enum logic [3:0] {
        MU_MULT  = 4'd0,
        MU_MULTU = 4'd1,
        MU_DIV   = 4'd2,
        MU_DIVU  = 4'd3,
        MU_MTHI  = 4'd4,
        MU_MTLO  = 4'd5,
        MU_MFHI  = 4'd6,
        MU_MFLO  = 4'd7,
        MU_NONE  = 4'd8
    } mu_op_e;

    localparam int unsigned MD_MULT_LAT = 5;
    localparam int unsigned MD_DIV_LAT  = 10;
    localparam int unsigned MD_CNT_W    = 4;

    typedef enum logic {
        LAT_IDLE,
        LAT_BUSY
    } lat_state_e;

    // Ops that launch a multi-cycle computation in the unit.
    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op == MU_MULT) || (op == MU_MULTU) || (op == MU_DIV) || (op == MU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MU_DIV) || (op == MU_DIVU);
    endfunction

endpackage

// File: rtl/md_lat_tracker.sv
// Shadow of the MD unit's busy window. Loads the expected latency on each
// Start, counts it down while the unit reports Busy, and raises a sticky
// lat_err on an early Busy drop, a Busy overrun, or Busy while idle.
// Everything freezes while req is high, mirroring the unit itself.
//   clk, reset   clock, synchronous active-high reset
//   req          exception/interrupt request (freeze)
//   md_start     Start pulse being issued this cycle
//   e_md_op      E-stage op, selects the latency to load
//   md_busy      unit Busy
//   lat_err      sticky mismatch flag
module md_lat_tracker
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT,
    parameter int unsigned CNT_W    = MD_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       md_start,
    input  logic [3:0] e_md_op,
    input  logic       md_busy,
    output logic       lat_err
);

    lat_state_e       state, state_n;
    logic [CNT_W-1:0] lat_cnt, lat_cnt_n;
    logic             lat_err_n;
    logic [CNT_W-1:0] lat_load;

    assign lat_load = is_div_op(e_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LAT_IDLE;
            lat_cnt <= '0;
            lat_err <= 1'b0;
        end else begin
            state   <= state_n;
            lat_cnt <= lat_cnt_n;
            lat_err <= lat_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        lat_cnt_n = lat_cnt;
        lat_err_n = lat_err;
        unique case (state)
            LAT_IDLE: begin
                if (!req && md_busy) begin
                    lat_err_n = 1'b1;
                end
                if (md_start) begin
                    state_n   = LAT_BUSY;
                    lat_cnt_n = lat_load;
                end
            end
            LAT_BUSY: begin
                if (!req) begin
                    if (md_busy) begin
                        if (lat_cnt != '0) begin
                            lat_cnt_n = lat_cnt - CNT_W'(1);
                        end else begin
                            lat_err_n = 1'b1;
                        end
                    end else begin
                        // Busy gone: window ends whether or not the count
                        // ran out; a non-zero count means the unit dropped early.
                        if (lat_cnt != '0) begin
                            lat_err_n = 1'b1;
                        end
                        if (md_start) begin
                            lat_cnt_n = lat_load;
                        end else begin
                            state_n   = LAT_IDLE;
                            lat_cnt_n = '0;
                        end
                    end
                end
            end
            default: begin
                state_n   = LAT_IDLE;
                lat_cnt_n = '0;
            end
        endcase
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit. Issues Start and the op
// code, holds off issue during an exception request, stalls D-stage MD-class
// instructions while the unit is busy, returns HI/LO for mfhi/mflo, and
// watches the unit's busy window for latency/protocol mismatches.
//   clk, reset   clock, synchronous active-high reset
//   e_valid      E-stage instruction valid
//   e_md_op      E-stage MD op code (md_pkg::mu_op_e values)
//   d_md_use     D-stage instruction is an MD-class op
//   req          exception/interrupt request
//   md_busy      unit Busy
//   md_hi/md_lo  unit HI/LO
//   md_start     Start to unit
//   md_op        op to unit, MU_NONE when invalid or under req
//   stall_d      freeze F/D, bubble E
//   e_mdout      mfhi/mflo result to E-stage result mux
//   lat_err      sticky latency/protocol mismatch
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT,
    parameter int unsigned CNT_W    = MD_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic        d_md_use,
    input  logic        req,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic        stall_d,
    output logic [31:0] e_mdout,
    output logic        lat_err
);

    if ((MULT_LAT > (2 ** CNT_W) - 1) || (DIV_LAT > (2 ** CNT_W) - 1)) begin : g_lat_chk
        $error("md_issue_ctrl: latency does not fit in CNT_W bits");
    end

    logic issue_ok;

    assign issue_ok = e_valid && !req;
    assign md_start = issue_ok && !md_busy && is_md_start_op(e_md_op) && !reset;
    assign md_op    = issue_ok ? e_md_op : 4'(MU_NONE);
    assign stall_d  = d_md_use && (md_start || md_busy);

    always_comb begin
        e_mdout = '0;
        if (e_md_op == 4'(MU_MFHI)) begin
            e_mdout = md_hi;
        end else if (e_md_op == 4'(MU_MFLO)) begin
            e_mdout = md_lo;
        end
    end

    md_lat_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_lat_tracker (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .md_start (md_start),
        .e_md_op  (e_md_op),
        .md_busy  (md_busy),
        .lat_err  (lat_err)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomized plus directed bench for md_issue_ctrl. A behavioural MD unit
// drives Busy/HI/LO; a reference model predicts every output for each cycle
// and pushes it to a scoreboard queue that a separate monitor drains.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic        d_md_use;
    logic        req;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_start;
    logic [3:0]  md_op;
    logic        stall_d;
    logic [31:0] e_mdout;
    logic        lat_err;

    md_issue_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_md_op  (e_md_op),
        .d_md_use (d_md_use),
        .req      (req),
        .md_busy  (md_busy),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .md_start (md_start),
        .md_op    (md_op),
        .stall_d  (stall_d),
        .e_mdout  (e_mdout),
        .lat_err  (lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [3:0]  op;
        logic        stall;
        logic [31:0] mdout;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Model state: cycles of Busy the unit still owes, the ideal Busy window
    // as seen by a correct protocol, and the expected sticky error.
    int unit_left  = 0;
    int ideal_left = 0;
    bit exp_err    = 0;

    function automatic int lat_of(input logic [3:0] op);
        return (op <= 4'd1) ? MULT_LAT : DIV_LAT;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, want);
        end
    endtask

    // One E-stage cycle. flip inverts the unit's Busy for this cycle (fault).
    task automatic cycle(input logic v, input logic [3:0] op, input logic du,
                         input logic rq, input logic rst, input logic flip);
        exp_t e;
        logic busy_drv;
        @(negedge clk);
        reset    = rst;
        e_valid  = v;
        e_md_op  = op;
        d_md_use = du;
        req      = rq;
        md_hi    = $urandom;
        md_lo    = $urandom;
        busy_drv = (unit_left > 0) ^ flip;
        md_busy  = busy_drv;
        #1;
        e.start = !rst && v && !rq && !busy_drv && (op < 4'd4);
        e.op    = (v && !rq) ? op : 4'd8;
        e.stall = du && (e.start || busy_drv);
        e.mdout = (op == 4'd6) ? md_hi : (op == 4'd7) ? md_lo : 32'd0;
        e.err   = exp_err;
        exp_q.push_back(e);
        if (rst) begin
            exp_err    = 0;
            ideal_left = 0;
            unit_left  = 0;
        end else if (!rq) begin
            if (busy_drv != (ideal_left > 0)) exp_err = 1;
            if (!busy_drv) ideal_left = 0;
            else if (ideal_left > 0) ideal_left--;
            if (unit_left > 0) unit_left--;
            if (e.start) begin
                ideal_left = lat_of(op);
                unit_left  = lat_of(op);
            end
        end
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd8, du, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("md_start", 32'(md_start), 32'(e.start));
                chk("md_op",    32'(md_op),    32'(e.op));
                chk("stall_d",  32'(stall_d),  32'(e.stall));
                chk("e_mdout",  e_mdout,       e.mdout);
                chk("lat_err",  32'(lat_err),  32'(e.err));
            end
        end
    end

    initial begin : driver
        reset = 1'b1; e_valid = 1'b0; e_md_op = 4'd8; d_md_use = 1'b0;
        req = 1'b0; md_busy = 1'b0; md_hi = '0; md_lo = '0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);

        // mult, stalled D user, then mflo as soon as the stall releases
        cycle(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(MULT_LAT, 1'b1);
        cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        // div with req in T+3, T+4
        cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(DIV_LAT - 2 + 1, 1'b1);

        // req in the issue cycle, then re-issue after the handler
        cycle(1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(MULT_LAT, 1'b1);

        // back-to-back multu then divu, mthi/mtlo pass-through
        cycle(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(MULT_LAT, 1'b1);
        cycle(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(DIV_LAT, 1'b1);
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // early Busy drop at T+3 of mult; error must stick until reset
        cycle(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(12, 1'b0);
        cycle(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);

        // spurious Busy while idle
        cycle(1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        cycle(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);

        // reset at T+2 of div
        cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // random traffic; faults only in the second half
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 9) < 8),
                  4'($urandom_range(0, 8)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 199) == 0),
                  (i >= 2000) && ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        #5;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        done = 1;
        $finish;
    end

endmodule
